// File: rtl/beam_energy_scanner.sv
// Steers an upstream beamformer across NUM_ANGLES angles, integrates |summed_value| per angle
// and reports the strongest angle. Optional abort input enabled by macro BEAM_SCAN_ABORT_EN.
module beam_energy_scanner #(
  parameter int DATA_W            = 36,
  parameter int ACC_W             = 48,
  parameter int NUM_ANGLES        = 16,
  parameter int SAMPLES_PER_ANGLE = 64,
  parameter int ANGLE_W           = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
`ifdef BEAM_SCAN_ABORT_EN
  input  logic               abort,
`endif
  input  logic [DATA_W-1:0]  summed_value,
  input  logic               sum_valid,
  output logic [ANGLE_W-1:0] steer_angle,
  output logic               steer_load,
  output logic               busy,
  output logic               done,
  output logic               result_valid,
  output logic [ANGLE_W-1:0] peak_angle,
  output logic [ACC_W-1:0]   peak_energy,
  output logic [2:0]         fsm_state
);

  // sum_valid qualifies summed_value with no backpressure: a sample counts only in ACCUM,
  // samples presented in any other state are dropped.
  localparam int CNT_W = (SAMPLES_PER_ANGLE > 1) ? $clog2(SAMPLES_PER_ANGLE + 1) : 1;
  localparam logic [CNT_W-1:0]   LAST_CNT   = CNT_W'(SAMPLES_PER_ANGLE - 1);
  localparam logic [ANGLE_W-1:0] LAST_ANGLE = ANGLE_W'(NUM_ANGLES - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    STEER   = 3'd1,
    ACCUM   = 3'd2,
    COMPARE = 3'd3,
    DONE    = 3'd4
  } state_t;

  state_t             state, state_d;
  logic [ACC_W-1:0]   acc, acc_d;
  logic [CNT_W-1:0]   cnt, cnt_d;
  logic [ANGLE_W-1:0] angle_d, peak_angle_d;
  logic [ACC_W-1:0]   peak_energy_d;
  logic               result_valid_d, steer_load_d, busy_d, done_d;
  logic               abort_hit;

  logic [DATA_W-1:0]  mag;
  logic [ACC_W:0]     acc_sum;
  logic [ACC_W-1:0]   acc_sat;

  // Magnitude is unsigned, so the most negative input maps to 2^(DATA_W-1) without overflow.
  assign mag     = summed_value[DATA_W-1] ? (~summed_value + DATA_W'(1)) : summed_value;
  assign acc_sum = {1'b0, acc} + {{(ACC_W + 1 - DATA_W){1'b0}}, mag};
  assign acc_sat = acc_sum[ACC_W] ? {ACC_W{1'b1}} : acc_sum[ACC_W-1:0];

`ifdef BEAM_SCAN_ABORT_EN
  assign abort_hit = abort && (state != IDLE);
`else
  assign abort_hit = 1'b0;
`endif

  assign fsm_state = state;

  always_comb begin
    state_d        = state;
    acc_d          = acc;
    cnt_d          = cnt;
    angle_d        = steer_angle;
    peak_angle_d   = peak_angle;
    peak_energy_d  = peak_energy;
    result_valid_d = result_valid;
    case (state)
      IDLE: begin
        if (start) begin
          state_d        = STEER;
          angle_d        = '0;
          result_valid_d = 1'b0;
          peak_angle_d   = '0;
          peak_energy_d  = '0;
        end
      end
      STEER: begin
        acc_d   = '0;
        cnt_d   = '0;
        state_d = ACCUM;
      end
      ACCUM: begin
        if (sum_valid) begin
          acc_d = acc_sat;
          cnt_d = cnt + CNT_W'(1);
          if (cnt == LAST_CNT) state_d = COMPARE;
        end
      end
      COMPARE: begin
        // Strict compare: on a tie the earlier (lower) angle keeps the peak.
        if ((steer_angle == '0) || (acc > peak_energy)) begin
          peak_energy_d = acc;
          peak_angle_d  = steer_angle;
        end
        if (steer_angle == LAST_ANGLE) begin
          state_d        = DONE;
          result_valid_d = 1'b1;
        end else begin
          angle_d = steer_angle + ANGLE_W'(1);
          state_d = STEER;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (abort_hit) begin
      state_d        = IDLE;
      result_valid_d = 1'b0;
      peak_angle_d   = '0;
      peak_energy_d  = '0;
    end
    // Pulse/level outputs are registered from the state being entered.
    steer_load_d = (state_d == STEER);
    busy_d       = (state_d != IDLE);
    done_d       = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      acc          <= '0;
      cnt          <= '0;
      steer_angle  <= '0;
      steer_load   <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      result_valid <= 1'b0;
      peak_angle   <= '0;
      peak_energy  <= '0;
    end else begin
      state        <= state_d;
      acc          <= acc_d;
      cnt          <= cnt_d;
      steer_angle  <= angle_d;
      steer_load   <= steer_load_d;
      busy         <= busy_d;
      done         <= done_d;
      result_valid <= result_valid_d;
      peak_angle   <= peak_angle_d;
      peak_energy  <= peak_energy_d;
    end
  end

endmodule

// File: doc/beam_energy_scanner.md
Name: beam_energy_scanner

Overview:
- Sits directly downstream of fullbeamformer and consumes its 36-bit summed_value output stream.
- Steps the beamformer through NUM_ANGLES steering angles and accumulates |summed_value| over SAMPLES_PER_ANGLE samples at each angle.
- Reports the angle with maximum accumulated energy: a scan-level peak/direction-of-arrival result for the output/display logic.

Parameters:
- DATA_W, 36: width of signed summed_value input.
- ACC_W, 48: width of unsigned energy accumulator and peak_energy; must be >= DATA_W.
- NUM_ANGLES, 16: steering angles per scan, indices 0..NUM_ANGLES-1.
- SAMPLES_PER_ANGLE, 64: valid samples accumulated per angle; must be >= 1.
- ANGLE_W, 4: width of angle indices; must be >= clog2(NUM_ANGLES).

Ports:
- clk, input, 1: system clock, rising edge.
- rst_n, input, 1: asynchronous active-low reset.
- start, input, 1: scan request; sampled only in IDLE.
- summed_value, input, DATA_W: signed two's-complement beamformer sum.
- sum_valid, input, 1: summed_value valid this cycle.
- steer_angle, output, ANGLE_W: angle the beamformer must use.
- steer_load, output, 1: one-cycle pulse; new steer_angle is valid.
- busy, output, 1: high from accepted start until DONE exits.
- done, output, 1: one-cycle pulse at scan completion.
- result_valid, output, 1: peak outputs hold a completed scan.
- peak_angle, output, ANGLE_W: angle with maximum energy.
- peak_energy, output, ACC_W: maximum accumulated energy.

Behaviour:
- All outputs are registered. Asynchronous reset (rst_n low) forces every output and all internal state to 0 and the FSM to IDLE, including mid-scan. No partial result is retained.
- FSM states: IDLE, STEER, ACCUM, COMPARE, DONE.
- IDLE: on start=1, go to STEER next cycle and set angle to 0. Also clear result_valid, peak_angle and peak_energy.
- STEER: steer_load=1 for exactly this one cycle and steer_angle=current angle. Clear acc and sample count. Next state is ACCUM.
- ACCUM: each cycle with sum_valid=1, acc <= sat(acc + |summed_value|) and count increments. sum_valid=0 holds state; gaps of any length are allowed.
- ACCUM exit: the cycle that accepts sample SAMPLES_PER_ANGLE-1 (0-based count) transitions to COMPARE.
- ACCUM samples during STEER and COMPARE are ignored.
- abs rule: |-2^(DATA_W-1)| = 2^(DATA_W-1), computed unsigned in DATA_W bits with no overflow.
- sat rule: if the sum exceeds 2^ACC_W-1, acc = 2^ACC_W-1 and stays clamped.
- COMPARE (one cycle): if angle==0 or acc > peak_energy (strict), load peak_energy=acc and peak_angle=angle.
  - Ties keep the lower angle.
  - If angle==NUM_ANGLES-1, go to DONE; else angle++ and go to STEER.
- DONE (one cycle): done=1, result_valid set at the same edge, then IDLE. busy drops on the edge leaving DONE.
- result_valid, peak_angle and peak_energy hold until the next accepted start.
- busy=1 in STEER, ACCUM, COMPARE and DONE. start is ignored while busy.
- steer_angle holds its last value in IDLE.
- Scan latency with gapless sum_valid: NUM_ANGLES*(SAMPLES_PER_ANGLE+2)+1 cycles from start to done.

Optional Feature:
- Macro: BEAM_SCAN_ABORT_EN.
- Defined: adds input port abort (1 bit). abort=1 in any busy state returns the FSM to IDLE at the next edge.
  - busy clears; result_valid stays 0; peak outputs are cleared to 0.
  - No done pulse is issued.
  - abort has priority over every other transition. abort in IDLE is ignored.
- Not defined: no abort port; a scan always runs to completion or reset.

Test Plan:
- Reset: assert rst_n=0 mid-ACCUM at angle 5 -> all outputs 0 immediately (asynchronous). After release, FSM in IDLE with busy=0.
- Basic scan (NUM_ANGLES=4, SAMPLES_PER_ANGLE=4, gapless):
  - Per-angle constant inputs 10, -20, 50, 30 -> steer_load pulses for angles 0,1,2,3.
  - Result: peak_angle=2, peak_energy=200, done pulse at cycle 25 after start, result_valid=1.
- Tie: per-angle inputs 7, 25, 3, -25 (×4) -> peak_angle=1, peak_energy=100.
- Saturation and abs edge (ACC_W=37, DATA_W=36): four samples of -2^35 at angle 0 -> acc=2^37-1 clamped, peak_energy=2^37-1.
- Gaps and start-while-busy:
  - sum_valid high one cycle in three, values as in the basic scan -> same result, done later.
  - start pulses during ACCUM -> ignored; single done.
- Abort (BEAM_SCAN_ABORT_EN): abort=1 in ACCUM of angle 2 -> IDLE next cycle, busy=0, no done, result_valid=0. A new start then completes a full scan normally.
